// File: rtl/issue_lane_pkg.sv
// Shared types for the issue-lane select/wakeup block: destination tag
// record and the non-pipelined occupancy state.
package issue_lane_pkg;

    localparam int PHYS_REG_W = 7;

    typedef struct packed {
        logic [PHYS_REG_W-1:0] reg_id;
        logic                  valid;
    } phys_reg_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } busy_state_t;

endpackage

// File: rtl/issue_rsr_delay.sv
// Wakeup delay line for pipelined non-simple ops: a tag entering here
// appears on out_o FU_LATENCY cycles after its grant cycle.
module issue_rsr_delay
    import issue_lane_pkg::*;
#(
    parameter int FU_LATENCY = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush_i,
    input  phys_reg_t in_i,
    output phys_reg_t out_o,
    output logic      ignore_o
);

    phys_reg_t stage_d [FU_LATENCY];
    phys_reg_t stage_q [FU_LATENCY];

    always_comb begin
        stage_d[0] = in_i;
        for (int k = 1; k < FU_LATENCY; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        if (flush_i) begin
            for (int k = 0; k < FU_LATENCY; k++) begin
                stage_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FU_LATENCY; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < FU_LATENCY; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_o = stage_q[FU_LATENCY-1];

    // Next-to-last stage broadcasts next cycle; a simple grant now would collide.
    if (FU_LATENCY >= 2) begin : g_ign
        assign ignore_o = stage_q[FU_LATENCY-2].valid;
    end else begin : g_no_ign
        assign ignore_o = 1'b0;
    end

endmodule

// File: rtl/issue_lane_mc.sv
// Issue-lane select, wakeup broadcast and non-pipelined occupancy control.
// Define ISSUE_THREE_DEEP_EN to register the grant outputs one cycle after select.
//
// state | meaning
// IDLE  | lane free, grants allowed
// BUSY  | non-pipelined op occupying lane, counter running down to its broadcast
module issue_lane_mc
    import issue_lane_pkg::*;
#(
    parameter int LANE_ID        = 0,
    parameter int IQ_DEPTH       = 32,
    parameter int PHYS_LOG       = 7,
    parameter int DISPATCH_WIDTH = 4,
    parameter int FU_LATENCY     = 3,
    parameter int BLOCK_LATENCY  = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush_i,
    input  logic                               laneActive_i,
    input  logic [IQ_DEPTH-1:0]                reqVect_i,
    input  logic [IQ_DEPTH-1:0]                laneMatch_i,
    input  logic [IQ_DEPTH-1:0]                isSimple_i,
    input  logic [IQ_DEPTH-1:0]                isBlocking_i,
    input  logic [IQ_DEPTH*(PHYS_LOG+1)-1:0]   phyDest_i,
    input  logic [DISPATCH_WIDTH*PHYS_LOG-1:0] dispSrc1_i,
    input  logic [DISPATCH_WIDTH*PHYS_LOG-1:0] dispSrc2_i,
    output logic                               grantValid_o,
    output logic [$clog2(IQ_DEPTH)-1:0]        grantId_o,
    output logic                               rsrValid_o,
    output logic [PHYS_LOG-1:0]                rsrTag_o,
    output logic [DISPATCH_WIDTH-1:0]          src1Match_o,
    output logic [DISPATCH_WIDTH-1:0]          src2Match_o,
    output logic                               laneBusy_o
);

    localparam int IDX_W  = $clog2(IQ_DEPTH);
    localparam int CNT_W  = $clog2(BLOCK_LATENCY);
    localparam int DEST_W = PHYS_LOG + 1;

    logic [IQ_DEPTH-1:0] elig;
    logic                ignore_simple, lane_busy, sel_valid, grant_fire;
    logic [IDX_W-1:0]    sel_id;
    logic [DEST_W-1:0]   sel_raw;
    phys_reg_t           sel_dest, simple_d, simple_q, pipe_in, pipe_out;
    phys_reg_t           held_d, held_q, blk_bcast, rsr;
    busy_state_t         state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;

    always_comb begin
        elig = reqVect_i & laneMatch_i & ~({IQ_DEPTH{ignore_simple}} & isSimple_i);
        if (!laneActive_i || lane_busy) begin
            elig = '0;
        end
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_valid = 1'b1;
                sel_id    = IDX_W'(i);
            end
        end
    end

    assign grant_fire = sel_valid & ~flush_i;
    assign sel_raw    = phyDest_i[sel_id*DEST_W +: DEST_W];

    always_comb begin
        sel_dest = '0;
        if (sel_raw[0]) begin
            sel_dest.valid  = 1'b1;
            sel_dest.reg_id = PHYS_REG_W'(sel_raw[PHYS_LOG:1]);
        end
        simple_d = '0;
        pipe_in  = '0;
        if (grant_fire && !isBlocking_i[sel_id]) begin
            if (isSimple_i[sel_id]) simple_d = sel_dest;
            else                    pipe_in  = sel_dest;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) simple_q <= '0;
        else       simple_q <= simple_d;
    end

    issue_rsr_delay #(
        .FU_LATENCY (FU_LATENCY)
    ) u_rsr_delay (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (flush_i),
        .in_i     (pipe_in),
        .out_o    (pipe_out),
        .ignore_o (ignore_simple)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        case (state_q)
            IDLE: begin
                if (grant_fire && isBlocking_i[sel_id]) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(BLOCK_LATENCY - 1);
                    held_d  = sel_dest;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    held_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush abandons the held blocking tag along with the occupancy.
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = '0;
        end
    end

    always_comb begin
        lane_busy = (state_q == BUSY);
        blk_bcast = '0;
        if (state_q == BUSY && cnt_q == '0) begin
            blk_bcast = held_q;
        end
    end

    // Sources never coincide: ignore_simple and lane occupancy keep them apart.
    always_comb begin
        rsr = '0;
        if (simple_q.valid)       rsr = simple_q;
        else if (pipe_out.valid)  rsr = pipe_out;
        else if (blk_bcast.valid) rsr = blk_bcast;
    end

    assign rsrValid_o = rsr.valid;
    assign rsrTag_o   = PHYS_LOG'(rsr.reg_id);
    assign laneBusy_o = lane_busy;

    always_comb begin
        src1Match_o = '0;
        src2Match_o = '0;
        for (int d = 0; d < DISPATCH_WIDTH; d++) begin
            src1Match_o[d] = rsrValid_o && (dispSrc1_i[d*PHYS_LOG +: PHYS_LOG] == rsrTag_o);
            src2Match_o[d] = rsrValid_o && (dispSrc2_i[d*PHYS_LOG +: PHYS_LOG] == rsrTag_o);
        end
    end

`ifdef ISSUE_THREE_DEEP_EN
    logic             grant_valid_d, grant_valid_q;
    logic [IDX_W-1:0] grant_id_d, grant_id_q;

    assign grant_valid_d = grant_fire;
    assign grant_id_d    = grant_fire ? sel_id : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign grantValid_o = grant_valid_q;
    assign grantId_o    = grant_id_q;
`else
    assign grantValid_o = grant_fire & ~reset;
    assign grantId_o    = (grant_fire && !reset) ? sel_id : '0;
`endif

endmodule

// File: tb/tb_issue_lane_mc.sv
// Self-checking bench for issue_lane_mc: cycle-scheduled reference model plus
// directed scenarios with literal expectations and a short random phase.
module tb_issue_lane_mc;

    localparam int IQ = 32;
    localparam int PL = 7;
    localparam int DW = 4;
    localparam int FU = 3;
    localparam int BL = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush_i;
    logic               laneActive_i;
    logic [IQ-1:0]      reqVect_i, laneMatch_i, isSimple_i, isBlocking_i;
    logic [IQ*(PL+1)-1:0] phyDest_i;
    logic [DW*PL-1:0]   dispSrc1_i, dispSrc2_i;
    logic               grantValid_o;
    logic [4:0]         grantId_o;
    logic               rsrValid_o;
    logic [PL-1:0]      rsrTag_o;
    logic [DW-1:0]      src1Match_o, src2Match_o;
    logic               laneBusy_o;

    issue_lane_mc #(
        .LANE_ID        (0),
        .IQ_DEPTH       (IQ),
        .PHYS_LOG       (PL),
        .DISPATCH_WIDTH (DW),
        .FU_LATENCY     (FU),
        .BLOCK_LATENCY  (BL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .laneActive_i (laneActive_i),
        .reqVect_i    (reqVect_i),
        .laneMatch_i  (laneMatch_i),
        .isSimple_i   (isSimple_i),
        .isBlocking_i (isBlocking_i),
        .phyDest_i    (phyDest_i),
        .dispSrc1_i   (dispSrc1_i),
        .dispSrc2_i   (dispSrc2_i),
        .grantValid_o (grantValid_o),
        .grantId_o    (grantId_o),
        .rsrValid_o   (rsrValid_o),
        .rsrTag_o     (rsrTag_o),
        .src1Match_o  (src1Match_o),
        .src2Match_o  (src2Match_o),
        .laneBusy_o   (laneBusy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: broadcasts scheduled by absolute cycle number.
    logic [6:0] sched [int];
    bit         pipe_sched [int];
    int         busy_end = -1;
    int         mcyc = 0;
    bit         prev_gv = 1'b0;
    int         prev_gid = 0;
    bit         m_busy, m_ign, m_sv, m_ev;
    int         m_sid;
    logic [7:0] m_d;
    logic [6:0] m_et;
    logic [3:0] m_s1, m_s2;
    int         m_kill [$];

    always @(negedge clk) begin
        if (reset) begin
            sched.delete();
            pipe_sched.delete();
            busy_end = -1;
            prev_gv  = 1'b0;
            prev_gid = 0;
            chk("rst_grant", 32'(grantValid_o), 32'(0));
            chk("rst_rsr", 32'({rsrValid_o, rsrTag_o}), 32'(0));
            chk("rst_busy", 32'(laneBusy_o), 32'(0));
            chk("rst_match", 32'({src1Match_o, src2Match_o}), 32'(0));
        end else begin
            m_busy = (mcyc <= busy_end);
            m_ign  = pipe_sched.exists(mcyc + 1);
            m_sv   = 1'b0;
            m_sid  = 0;
            if (laneActive_i && !m_busy && !flush_i) begin
                for (int i = 0; i < IQ; i++) begin
                    if (!m_sv && reqVect_i[i] && laneMatch_i[i] && !(m_ign && isSimple_i[i])) begin
                        m_sv  = 1'b1;
                        m_sid = i;
                    end
                end
            end
            m_ev = sched.exists(mcyc);
            m_et = m_ev ? sched[mcyc] : 7'd0;
            for (int s = 0; s < DW; s++) begin
                m_s1[s] = m_ev && (dispSrc1_i[s*PL +: PL] == m_et);
                m_s2[s] = m_ev && (dispSrc2_i[s*PL +: PL] == m_et);
            end
`ifdef ISSUE_THREE_DEEP_EN
            chk("grant_valid", 32'(grantValid_o), 32'(prev_gv));
            chk("grant_id", 32'(grantId_o), 32'(prev_gid));
`else
            chk("grant_valid", 32'(grantValid_o), 32'(m_sv));
            chk("grant_id", 32'(grantId_o), 32'(m_sv ? m_sid : 0));
`endif
            chk("rsr_valid", 32'(rsrValid_o), 32'(m_ev));
            chk("rsr_tag", 32'(rsrTag_o), 32'(m_et));
            chk("lane_busy", 32'(laneBusy_o), 32'(m_busy));
            chk("src1_match", 32'(src1Match_o), 32'(m_s1));
            chk("src2_match", 32'(src2Match_o), 32'(m_s2));
            prev_gv  = m_sv;
            prev_gid = m_sv ? m_sid : 0;
            if (m_sv) begin
                m_d = phyDest_i[m_sid*8 +: 8];
                if (isBlocking_i[m_sid]) begin
                    busy_end = mcyc + BL;
                    if (m_d[0]) sched[mcyc + BL] = m_d[7:1];
                end else if (isSimple_i[m_sid]) begin
                    if (m_d[0]) sched[mcyc + 1] = m_d[7:1];
                end else if (m_d[0]) begin
                    sched[mcyc + FU]      = m_d[7:1];
                    pipe_sched[mcyc + FU] = 1'b1;
                end
            end
            if (flush_i) begin
                if (busy_end > mcyc) busy_end = mcyc;
                m_kill.delete();
                foreach (sched[k]) if (k > mcyc) m_kill.push_back(k);
                foreach (m_kill[j]) sched.delete(m_kill[j]);
                m_kill.delete();
                foreach (pipe_sched[k]) if (k > mcyc) m_kill.push_back(k);
                foreach (m_kill[j]) pipe_sched.delete(m_kill[j]);
            end
        end
        mcyc++;
    end

    task automatic cyc_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        reqVect_i    = '0;
        laneMatch_i  = '1;
        isSimple_i   = '1;
        isBlocking_i = '0;
        phyDest_i    = '0;
        dispSrc1_i   = '0;
        dispSrc2_i   = '0;
        flush_i      = 1'b0;
        laneActive_i = 1'b1;
    endtask

    task automatic set_dest(input int idx, input logic [6:0] tag, input logic dv);
        phyDest_i[idx*8 +: 8] = {tag, dv};
    endtask

    initial begin
        idle_in();
        reset     = 1'b1;
        reqVect_i = 32'h1;
        #2;
        chk("reset_grant_lit", 32'(grantValid_o), 32'(0));
        chk("reset_busy_lit", 32'(laneBusy_o), 32'(0));
        #10;
        reset = 1'b0;
        idle_in();
        cyc_next();
        cyc_next();

        // Two simple ops, lowest index first
        reqVect_i = 32'h0C;
        set_dest(2, 7'h15, 1'b1);
        set_dest(3, 7'h16, 1'b1);
        #2;
`ifndef ISSUE_THREE_DEEP_EN
        chk("a_gv_lit", 32'(grantValid_o), 32'(1));
        chk("a_gid_lit", 32'(grantId_o), 32'(2));
`endif
        cyc_next();
        reqVect_i = 32'h08;
        #2;
        chk("a_rsr1_lit", 32'({rsrValid_o, rsrTag_o}), 32'({1'b1, 7'h15}));
        cyc_next();
        reqVect_i = '0;
        #2;
        chk("a_rsr2_lit", 32'({rsrValid_o, rsrTag_o}), 32'({1'b1, 7'h16}));
        cyc_next();

        // Non-simple entry 5 blocks a simple grant two cycles later
        idle_in();
        isSimple_i = ~32'h20;
        reqVect_i  = 32'h20;
        set_dest(5, 7'h2A, 1'b1);
        set_dest(1, 7'h11, 1'b1);
        cyc_next();
        reqVect_i = '0;
        cyc_next();
        reqVect_i = 32'h02;
        #2;
`ifndef ISSUE_THREE_DEEP_EN
        chk("b_hold_lit", 32'(grantValid_o), 32'(0));
`endif
        cyc_next();
        #2;
`ifndef ISSUE_THREE_DEEP_EN
        chk("b_gid_lit", 32'({grantValid_o, grantId_o}), 32'({1'b1, 5'd1}));
`endif
        chk("b_rsr1_lit", 32'({rsrValid_o, rsrTag_o}), 32'({1'b1, 7'h2A}));
        cyc_next();
        reqVect_i = '0;
        #2;
        chk("b_rsr2_lit", 32'({rsrValid_o, rsrTag_o}), 32'({1'b1, 7'h11}));
        cyc_next();

        // Blocking op occupies the lane for BL cycles
        idle_in();
        reqVect_i    = 32'h1;
        isBlocking_i = 32'h1;
        isSimple_i   = ~32'h1;
        set_dest(0, 7'h33, 1'b1);
        set_dest(4, 7'h44, 1'b1);
        cyc_next();
        reqVect_i = 32'h10;
        for (int k = 1; k <= BL; k++) begin
            #2;
            chk("c_busy_lit", 32'(laneBusy_o), 32'(1));
            if (k == BL) chk("c_blk_bcast_lit", 32'({rsrValid_o, rsrTag_o}), 32'({1'b1, 7'h33}));
            cyc_next();
        end
        #2;
        chk("c_free_lit", 32'(laneBusy_o), 32'(0));
`ifndef ISSUE_THREE_DEEP_EN
        chk("c_next_grant_lit", 32'({grantValid_o, grantId_o}), 32'({1'b1, 5'd4}));
`endif
        cyc_next();
        reqVect_i = '0;
        #2;
        chk("c_rsr_lit", 32'({rsrValid_o, rsrTag_o}), 32'({1'b1, 7'h44}));
        cyc_next();

        // Flush in the middle of a blocking op
        idle_in();
        reqVect_i    = 32'h1;
        isBlocking_i = 32'h1;
        isSimple_i   = ~32'h1;
        set_dest(0, 7'h35, 1'b1);
        set_dest(4, 7'h44, 1'b1);
        cyc_next();
        reqVect_i = '0;
        cyc_next();
        cyc_next();
        cyc_next();
        flush_i   = 1'b1;
        reqVect_i = 32'h10;
        cyc_next();
        flush_i = 1'b0;
        #2;
        chk("d_free_lit", 32'(laneBusy_o), 32'(0));
`ifndef ISSUE_THREE_DEEP_EN
        chk("d_grant_lit", 32'({grantValid_o, grantId_o}), 32'({1'b1, 5'd4}));
`endif
        cyc_next();
        reqVect_i = '0;
        #2;
        chk("d_rsr_lit", 32'({rsrValid_o, rsrTag_o}), 32'({1'b1, 7'h44}));
        cyc_next();
        cyc_next();
        #2;
        chk("d_no_stale_lit", 32'(rsrValid_o), 32'(0));
        cyc_next();

        // Flush overrides a simultaneous simple grant
        idle_in();
        reqVect_i = 32'h1;
        set_dest(0, 7'h3C, 1'b1);
        flush_i = 1'b1;
        #2;
`ifndef ISSUE_THREE_DEEP_EN
        chk("e_flush_grant_lit", 32'(grantValid_o), 32'(0));
`endif
        cyc_next();
        reqVect_i = '0;
        flush_i   = 1'b0;
        #2;
        chk("e_flush_rsr_lit", 32'(rsrValid_o), 32'(0));
        cyc_next();

        // Source match against the broadcast tag
        idle_in();
        reqVect_i = 32'h100;
        set_dest(8, 7'h21, 1'b1);
        cyc_next();
        reqVect_i = '0;
        dispSrc1_i[3*PL +: PL] = 7'h21;
        dispSrc1_i[1*PL +: PL] = 7'h20;
        dispSrc2_i[0*PL +: PL] = 7'h21;
        #2;
        chk("f_src1_lit", 32'(src1Match_o), 32'(4'b1000));
        chk("f_src2_lit", 32'(src2Match_o), 32'(4'b0001));
        cyc_next();
        #2;
        chk("f_src1_off_lit", 32'(src1Match_o), 32'(0));
        cyc_next();

        // Lane disabled, then lane steering mask
        idle_in();
        reqVect_i    = 32'hF0;
        laneActive_i = 1'b0;
        #2;
`ifndef ISSUE_THREE_DEEP_EN
        chk("g_inactive_lit", 32'(grantValid_o), 32'(0));
`endif
        cyc_next();
        laneActive_i = 1'b1;
        laneMatch_i  = 32'hC0;
        #2;
`ifndef ISSUE_THREE_DEEP_EN
        chk("g_match_lit", 32'({grantValid_o, grantId_o}), 32'({1'b1, 5'd6}));
`endif
        cyc_next();

        // Reset in mid-flight: pipelined op pending, lane busy
        idle_in();
        isSimple_i = '0;
        reqVect_i  = 32'h4;
        set_dest(2, 7'h55, 1'b1);
        cyc_next();
        isBlocking_i = 32'h8;
        reqVect_i    = 32'h8;
        set_dest(3, 7'h56, 1'b1);
        cyc_next();
        reqVect_i = 32'h1;
        #1;
        chk("h_busy_lit", 32'(laneBusy_o), 32'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("h_rst_out_lit", 32'({grantValid_o, rsrValid_o, rsrTag_o, laneBusy_o}), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_in();
        for (int k = 0; k < 10; k++) begin
            cyc_next();
            #2;
            chk("h_no_stale_lit", 32'({rsrValid_o, laneBusy_o}), 32'(0));
        end
        cyc_next();

        // Random phase, checked against the model only
        for (int n = 0; n < 200; n++) begin
            reqVect_i    = $urandom;
            laneMatch_i  = $urandom | $urandom;
            isSimple_i   = $urandom;
            isBlocking_i = $urandom & $urandom & $urandom & $urandom & $urandom;
            for (int e = 0; e < IQ; e++) begin
                phyDest_i[e*8 +: 8] = {7'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            end
            for (int s = 0; s < DW; s++) begin
                dispSrc1_i[s*PL +: PL] = 7'($urandom_range(0, 7));
                dispSrc2_i[s*PL +: PL] = 7'($urandom_range(0, 7));
            end
            laneActive_i = ($urandom_range(0, 7) != 0);
            flush_i      = ($urandom_range(0, 24) == 0);
            cyc_next();
        end
        idle_in();
        for (int k = 0; k < 12; k++) cyc_next();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_lane_mc.md
ISSUE_LANE_MC -- requirements
Module: issue_lane_mc

Interface
REQ-001 SHALL have parameter LANE_ID, default 0, execution-lane index.
REQ-002 SHALL have parameter IQ_DEPTH, default 32, issue-queue entries (power of two).
REQ-003 SHALL have parameter PHYS_LOG, default 7, physical-register tag width.
REQ-004 SHALL have parameter DISPATCH_WIDTH, default 4, dispatch slots checked for bypass match.
REQ-005 SHALL have parameter FU_LATENCY, default 3, writeback latency of non-simple pipelined ops (>=1).
REQ-006 SHALL have parameter BLOCK_LATENCY, default 8, occupancy of non-pipelined ops (> FU_LATENCY).
REQ-007 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port flush_i  input  1  synchronous pipeline flush.
REQ-010 SHALL have port laneActive_i  input  1  lane enabled; 0 suppresses all grants.
REQ-011 SHALL have port reqVect_i  input  IQ_DEPTH  entry valid, unscheduled, operands ready.
REQ-012 SHALL have port laneMatch_i  input  IQ_DEPTH  entry steered to this lane.
REQ-013 SHALL have port isSimple_i  input  IQ_DEPTH  entry is single-cycle op.
REQ-014 SHALL have port isBlocking_i  input  IQ_DEPTH  entry is non-pipelined op.
REQ-015 SHALL have port phyDest_i  input  IQ_DEPTH*(PHYS_LOG+1)  per-entry {tag, destValid}.
REQ-016 SHALL have port dispSrc1_i / dispSrc2_i  input  DISPATCH_WIDTH*PHYS_LOG  dispatching source tags.
REQ-017 SHALL have port grantValid_o  output  1  grant this cycle.
REQ-018 SHALL have port grantId_o  output  log2(IQ_DEPTH)  granted entry.
REQ-019 SHALL have port rsrValid_o / rsrTag_o  output  1 / PHYS_LOG  wakeup broadcast; tag 0 when invalid.
REQ-020 SHALL have port src1Match_o / src2Match_o  output  DISPATCH_WIDTH  dispatch source equals valid rsrTag_o.
REQ-021 SHALL have port laneBusy_o  output  1  non-pipelined op occupying lane.

Function
REQ-022 Eligible[i] SHALL = reqVect_i & laneMatch_i & laneActive_i & ~laneBusy_o & ~(ignoreSimple & isSimple_i).
REQ-023 Select SHALL grant lowest-index eligible entry, combinationally, same cycle.
REQ-024 Simple granted op with destValid at cycle t SHALL broadcast its tag at t+1.
REQ-025 Non-simple pipelined op granted at t with destValid SHALL broadcast at t+FU_LATENCY.
REQ-026 ignoreSimple SHALL be high when a non-simple op will broadcast at t+1 (FU_LATENCY>=2), else 0.
REQ-027 FSM states IDLE, BUSY; grant of blocking entry in IDLE SHALL enter BUSY with counter = BLOCK_LATENCY-1.
REQ-028 In BUSY counter SHALL decrement each cycle; at 0 SHALL return to IDLE, broadcast held blocking tag (if destValid) that cycle; grants allowed next cycle.
REQ-029 laneBusy_o SHALL be high exactly in BUSY.
REQ-030 src match SHALL compare combinationally against current rsrTag_o, gated by rsrValid_o.
REQ-031 No grants, ready but ineligible entries SHALL retain no lane state.

Reset
REQ-032 Reset SHALL asynchronously force FSM IDLE, counter 0, delay line empty, all outputs 0.
REQ-033 flush_i SHALL have same effect synchronously, overriding a simultaneous grant; mid-BUSY flush drops held tag.

Configuration
REQ-034 With ISSUE_THREE_DEEP_EN defined, grantValid_o/grantId_o SHALL be registered (one cycle later), cleared by reset/flush; broadcast timing relative to select unchanged.
REQ-035 Without ISSUE_THREE_DEEP_EN, grant outputs SHALL be combinational per REQ-023.

Structure
REQ-036 Package issue_lane_pkg SHALL hold phys_reg_t {reg_id, valid} and busy_state_t enum.
REQ-037 Delay line SHALL be sub-module issue_rsr_delay, parameterised by FU_LATENCY.

Verification
REQ-038 reqVect=0x0C, laneMatch=0xFF, all simple, dest tag 0x15 at entry 2 -> grantId=2 cycle t, rsrTag=0x15 valid at t+1.
REQ-039 Non-simple entry 5 (FU_LATENCY=3) granted t, simple entry 1 ready at t+2 -> entry 1 not granted t+2, granted t+3; broadcasts t+3 and t+4.
REQ-040 Blocking entry 0 granted t -> laneBusy_o t+1..t+8, tag broadcast t+8, next grant t+9.
REQ-041 Flush at t+4 of blocking op -> laneBusy_o 0 at t+5, no broadcast, grant allowed t+5.
REQ-042 rsrTag=0x21 valid, dispSrc1 slot 3=0x21 -> src1Match_o=4'b1000; rsrValid 0 -> 0.
REQ-043 Reset asserted mid-pipeline -> all outputs 0 immediately, no stale broadcast after release.
